// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: bus field widths,
// FSM state encoding, default forced-completion data and the grant decision.
package wb_master_arbiter_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  localparam logic [DAT_W-1:0] TIMEOUT_DATA_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TMO  = 2'd2
  } arb_state_e;

  // One-hot grant; on a tie the master that did not own the bus last time wins.
  function automatic logic [1:0] pick_grant(input logic [1:0] req, input logic last_owner);
    logic [1:0] g;
    g = 2'b00;
    if (req == 2'b11) begin
      g = last_owner ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      g = 2'b01;
    end else if (req[1]) begin
      g = 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating stall counter for the bus watchdog; hit flags the cycle whose
// increment reaches LIMIT. LIMIT = 0 disables the watchdog entirely.
module wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic arstn,
  input  logic en,
  input  logic clr,
  output logic hit
);

  localparam int            CW    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM   = CW'(LIMIT);
  localparam bit            WD_ON = (LIMIT != 0);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != LIM)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign hit = WD_ON && en && !clr && (count_reg >= (LIM - 1'b1));

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone classic arbiter in front of the xbar master
// port; tenure lasts the whole cyc and a watchdog force-completes hung accesses.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int               TIMEOUT_CYCLES = 255,
  parameter logic [DAT_W-1:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [DAT_W-1:0] m0_wdat,
  input  logic             m0_we,
  input  logic             m0_stb,
  input  logic             m0_cyc,
  input  logic [SEL_W-1:0] m0_sel,
  output logic [DAT_W-1:0] m0_rdat,
  output logic             m0_ack,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [DAT_W-1:0] m1_wdat,
  input  logic             m1_we,
  input  logic             m1_stb,
  input  logic             m1_cyc,
  input  logic [SEL_W-1:0] m1_sel,
  output logic [DAT_W-1:0] m1_rdat,
  output logic             m1_ack,
  output logic [ADR_W-1:0] s_adr,
  output logic [DAT_W-1:0] s_wdat,
  output logic             s_we,
  output logic             s_stb,
  output logic             s_cyc,
  output logic [SEL_W-1:0] s_sel,
  input  logic [DAT_W-1:0] s_rdat,
  input  logic             s_ack,
  output logic [1:0]       grant,
  output logic             timeout_o
);

  arb_state_e       state_reg;
  logic [1:0]       grant_reg;
  logic             last_reg;

  logic             own_cyc;
  logic             own_stb;
  logic             own_we;
  logic [ADR_W-1:0] own_adr;
  logic [DAT_W-1:0] own_wdat;
  logic [SEL_W-1:0] own_sel;

  logic             in_busy;
  logic             in_tmo;
  logic             wd_en;
  logic             wd_clr;
  logic             wd_hit;
  logic [DAT_W-1:0] rdat_mux;
  logic [1:0]       ack_vec;

  // Grant is one-hot, so the owner's fields can be selected by priority.
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_adr  = '0;
    own_wdat = '0;
    own_sel  = '0;
    if (grant_reg[1]) begin
      own_cyc  = m1_cyc;
      own_stb  = m1_stb;
      own_we   = m1_we;
      own_adr  = m1_adr;
      own_wdat = m1_wdat;
      own_sel  = m1_sel;
    end else if (grant_reg[0]) begin
      own_cyc  = m0_cyc;
      own_stb  = m0_stb;
      own_we   = m0_we;
      own_adr  = m0_adr;
      own_wdat = m0_wdat;
      own_sel  = m0_sel;
    end
  end

  assign in_busy = (state_reg == ST_BUSY);
  assign in_tmo  = (state_reg == ST_TMO);

  assign s_cyc  = in_busy & own_cyc;
  assign s_stb  = in_busy & own_cyc & own_stb;
  assign s_we   = own_we;
  assign s_adr  = own_adr;
  assign s_wdat = own_wdat;
  assign s_sel  = own_sel;

  // During the forced completion the slave is disconnected and its ack/data ignored.
  assign rdat_mux = in_tmo ? TIMEOUT_DATA : (in_busy ? s_rdat : '0);
  assign m0_rdat  = rdat_mux;
  assign m1_rdat  = rdat_mux;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = grant_reg[gi] & (in_tmo | (in_busy & s_ack));
    end
  endgenerate

  assign m0_ack    = ack_vec[0];
  assign m1_ack    = ack_vec[1];
  assign grant     = grant_reg;
  assign timeout_o = in_tmo;

  assign wd_en  = s_stb & ~s_ack;
  assign wd_clr = ~s_stb | s_ack;

  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .arstn (arstn),
    .en    (wd_en),
    .clr   (wd_clr),
    .hit   (wd_hit)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_reg <= ST_IDLE;
      grant_reg <= 2'b00;
      last_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (m0_cyc || m1_cyc) begin
            grant_reg <= pick_grant({m1_cyc, m0_cyc}, last_reg);
            state_reg <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!own_cyc) begin
            last_reg  <= grant_reg[1];
            grant_reg <= 2'b00;
            state_reg <= ST_IDLE;
          end else if (wd_hit) begin
            state_reg <= ST_TMO;
          end
        end
        ST_TMO: begin
          if (own_cyc) begin
            state_reg <= ST_BUSY;
          end else begin
            last_reg  <= grant_reg[1];
            grant_reg <= 2'b00;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          grant_reg <= 2'b00;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter (watchdog limit of 8 cycles).
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        arstn;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic        m0_we, m0_stb, m0_cyc, m0_ack;
  logic        m1_we, m1_stb, m1_cyc, m1_ack;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        s_we, s_stb, s_cyc, s_ack;
  logic [1:0]  grant;
  logic        timeout_o;
  logic [139:0] all_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign all_out = {m0_rdat, m0_ack, m1_rdat, m1_ack, s_adr, s_wdat,
                    s_we, s_stb, s_cyc, s_sel, grant, timeout_o};

  wb_master_arbiter #(
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_DATA   (32'hFFFF_FFFF)
  ) dut (
    .clk       (clk),
    .arstn     (arstn),
    .m0_adr    (m0_adr),
    .m0_wdat   (m0_wdat),
    .m0_we     (m0_we),
    .m0_stb    (m0_stb),
    .m0_cyc    (m0_cyc),
    .m0_sel    (m0_sel),
    .m0_rdat   (m0_rdat),
    .m0_ack    (m0_ack),
    .m1_adr    (m1_adr),
    .m1_wdat   (m1_wdat),
    .m1_we     (m1_we),
    .m1_stb    (m1_stb),
    .m1_cyc    (m1_cyc),
    .m1_sel    (m1_sel),
    .m1_rdat   (m1_rdat),
    .m1_ack    (m1_ack),
    .s_adr     (s_adr),
    .s_wdat    (s_wdat),
    .s_we      (s_we),
    .s_stb     (s_stb),
    .s_cyc     (s_cyc),
    .s_sel     (s_sel),
    .s_rdat    (s_rdat),
    .s_ack     (s_ack),
    .grant     (grant),
    .timeout_o (timeout_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_ack = 1'b0; s_rdat = 32'h0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_power_up: outputs=%h required 0", all_out);
    end
    @(negedge clk);
    arstn = 1'b1;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'hF;
    m0_adr = 32'h1000_0040; m0_wdat = 32'hCAFE_F00D; s_rdat = 32'hDEAD_BEEF;
    settle();
    checks++;
    if ({grant, s_cyc} !== 3'b000) begin
      errors++;
      $display("FAIL reset_first_idle: {grant,s_cyc}=%b required 000", {grant, s_cyc});
    end
    tick();
    settle();
    checks++;
    if ({grant, s_cyc, s_stb, s_we} !== 5'b01111) begin
      errors++;
      $display("FAIL reset_busy_setup: {grant,s_cyc,s_stb,s_we}=%b required 01111", {grant, s_cyc, s_stb, s_we});
    end
    #1 arstn = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_busy: outputs=%h required 0", all_out);
    end
    $display("[%0t] reset: asserted mid-BUSY, outputs=%h", $time, all_out);
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; s_rdat = 32'h0;
    @(negedge clk);
    arstn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      checks++;
      if ({grant, s_cyc} !== 3'b000) begin
        errors++;
        $display("FAIL reset_post_release_c%0d: {grant,s_cyc}=%b required 000", c, {grant, s_cyc});
      end
    end
  endtask

  task automatic test_contention();
    int         rem [2];
    bit         gap [2];
    logic [1:0] runs [$];
    logic [1:0] exp_runs [5];
    logic [1:0] prev_g;
    logic [1:0] got;
    int         n;
    rem = '{4, 4};
    gap = '{1'b0, 1'b0};
    exp_runs = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    prev_g = 2'b00;
    n = 0;
    m0_adr = 32'h0000_1000; m0_we = 1'b0; m0_sel = 4'hF;
    m1_adr = 32'h0000_2000; m1_we = 1'b0; m1_sel = 4'h3;
    while ((rem[0] > 0 || rem[1] > 0) && n < 60) begin
      tick();
      if (gap[0]) begin m0_cyc = 1'b0; gap[0] = 1'b0; end else m0_cyc = (rem[0] > 0);
      if (gap[1]) begin m1_cyc = 1'b0; gap[1] = 1'b0; end else m1_cyc = (rem[1] > 0);
      m0_stb = m0_cyc;
      m1_stb = m1_cyc;
      s_rdat = 32'hA500_0000 + 32'(n);
      #1 s_ack = s_stb;
      settle();
      if (grant !== prev_g) begin
        runs.push_back(grant);
        prev_g = grant;
      end
      if (m0_ack === 1'b1) begin
        checks++;
        if (m1_ack !== 1'b0 || m0_rdat !== s_rdat || s_adr !== 32'h0000_1000) begin
          errors++;
          $display("FAIL contention_m0_ack: m1_ack=%b rdat=%h adr=%h required 0/%h/00001000", m1_ack, m0_rdat, s_adr, s_rdat);
        end
        $display("[%0t] contention: m0 access acked rdat=%h", $time, m0_rdat);
        rem[0]--;
        gap[0] = 1'b1;
      end
      if (m1_ack === 1'b1) begin
        checks++;
        if (m0_ack !== 1'b0 || m1_rdat !== s_rdat || s_adr !== 32'h0000_2000) begin
          errors++;
          $display("FAIL contention_m1_ack: m0_ack=%b rdat=%h adr=%h required 0/%h/00002000", m0_ack, m1_rdat, s_adr, s_rdat);
        end
        $display("[%0t] contention: m1 access acked rdat=%h", $time, m1_rdat);
        rem[1]--;
        gap[1] = 1'b1;
      end
      n++;
    end
    checks++;
    if (rem[0] != 0 || rem[1] != 0) begin
      errors++;
      $display("FAIL contention_done: remaining m0=%0d m1=%0d required 0/0", rem[0], rem[1]);
    end
    for (int k = 0; k < 5; k++) begin
      got = (k < runs.size()) ? runs[k] : 2'bxx;
      checks++;
      if (got !== exp_runs[k]) begin
        errors++;
        $display("FAIL contention_grant_seq[%0d]: grant=%b required %b", k, got, exp_runs[k]);
      end
    end
    idle_bus();
  endtask

  task automatic test_single();
    logic [6:0] cyc_v, ack_v, scyc_v, mack_v;
    logic [1:0] g_exp [7];
    logic [4:0] exp_v;
    cyc_v = 7'b0011111; ack_v = 7'b0010000; scyc_v = 7'b0011110; mack_v = 7'b0010000;
    g_exp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    m0_adr = 32'hF000_0000; m0_we = 1'b0; m0_sel = 4'hF; m0_wdat = 32'h0;
    for (int c = 0; c < 7; c++) begin
      tick();
      m0_cyc = cyc_v[c];
      m0_stb = cyc_v[c];
      s_ack  = ack_v[c];
      s_rdat = ack_v[c] ? 32'h1234_5678 : 32'h0BAD_0000;
      settle();
      exp_v = {scyc_v[c], g_exp[c], mack_v[c], 1'b0};
      checks++;
      if ({s_cyc, grant, m0_ack, m1_ack} !== exp_v) begin
        errors++;
        $display("FAIL single_c%0d: {s_cyc,grant,m0_ack,m1_ack}=%b required %b", c, {s_cyc, grant, m0_ack, m1_ack}, exp_v);
      end
      if (c == 1) begin
        checks++;
        if (s_adr !== 32'hF000_0000 || s_we !== 1'b0 || s_stb !== 1'b1) begin
          errors++;
          $display("FAIL single_addr: adr=%h we=%b stb=%b required F0000000/0/1", s_adr, s_we, s_stb);
        end
      end
      if (c == 4) begin
        checks++;
        if (m0_rdat !== 32'h1234_5678) begin
          errors++;
          $display("FAIL single_rdat: m0_rdat=%h required 12345678", m0_rdat);
        end
        $display("[%0t] single: m0 read F0000000 -> %h", $time, m0_rdat);
      end
    end
    idle_bus();
  endtask

  task automatic test_block_hold();
    logic [8:0] m1c_v, m1s_v, m0c_v, ack_v, scyc_v, m1a_v, m0a_v;
    logic [1:0] g_exp [9];
    logic [4:0] exp_v;
    m1c_v = 9'b000111111; m1s_v = 9'b000101011; m0c_v = 9'b111111110;
    ack_v = 9'b100101010; scyc_v = 9'b100111110; m1a_v = 9'b000101010; m0a_v = 9'b100000000;
    g_exp = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    m0_adr = 32'h3000_0000; m1_adr = 32'h2000_0000;
    for (int c = 0; c < 9; c++) begin
      tick();
      m1_cyc = m1c_v[c];
      m1_stb = m1s_v[c];
      m0_cyc = m0c_v[c];
      m0_stb = m0c_v[c];
      s_ack  = ack_v[c];
      s_rdat = 32'hB000_0000 + 32'(c);
      settle();
      exp_v = {scyc_v[c], g_exp[c], m0a_v[c], m1a_v[c]};
      checks++;
      if ({s_cyc, grant, m0_ack, m1_ack} !== exp_v) begin
        errors++;
        $display("FAIL block_hold_c%0d: {s_cyc,grant,m0_ack,m1_ack}=%b required %b", c, {s_cyc, grant, m0_ack, m1_ack}, exp_v);
      end
      if (m1a_v[c]) $display("[%0t] block_hold: m1 phase acked rdat=%h", $time, m1_rdat);
      if (c == 8) begin
        checks++;
        if (s_adr !== 32'h3000_0000) begin
          errors++;
          $display("FAIL block_hold_m0_addr: s_adr=%h required 30000000", s_adr);
        end
        $display("[%0t] block_hold: m0 granted after m1 tenure, rdat=%h", $time, m0_rdat);
      end
    end
    idle_bus();
  endtask

  task automatic test_timeout();
    logic [1:0] g_e;
    logic [6:0] got_v, exp_v;
    m0_adr = 32'h4000_0000;
    for (int c = 0; c < 12; c++) begin
      tick();
      m0_cyc = (c <= 9);
      m0_stb = (c <= 9);
      s_ack  = (c == 9);
      s_rdat = 32'h5555_5555;
      settle();
      g_e   = (c >= 1 && c <= 10) ? 2'b01 : 2'b00;
      exp_v = {(c >= 1 && c <= 8), (c >= 1 && c <= 8), g_e, (c == 9), 1'b0, (c == 9)};
      got_v = {s_cyc, s_stb, grant, m0_ack, m1_ack, timeout_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL timeout_c%0d: {s_cyc,s_stb,grant,m0_ack,m1_ack,timeout_o}=%b required %b", c, got_v, exp_v);
      end
      if (c == 9) begin
        checks++;
        if (m0_rdat !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL timeout_rdat: m0_rdat=%h required FFFFFFFF", m0_rdat);
        end
        $display("[%0t] timeout: forced completion rdat=%h", $time, m0_rdat);
      end
    end
    idle_bus();
  endtask

  task automatic test_abort();
    logic [5:0] m0c_v, m1c_v, ack_v, scyc_v, m1a_v;
    logic [1:0] g_exp [6];
    logic [4:0] exp_v;
    m0c_v = 6'b000111; m1c_v = 6'b111110; ack_v = 6'b100000; scyc_v = 6'b100110; m1a_v = 6'b100000;
    g_exp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
    m0_adr = 32'h5000_0000; m1_adr = 32'h6000_0000;
    for (int c = 0; c < 6; c++) begin
      tick();
      m0_cyc = m0c_v[c];
      m0_stb = m0c_v[c];
      m1_cyc = m1c_v[c];
      m1_stb = m1c_v[c];
      s_ack  = ack_v[c];
      s_rdat = 32'hC000_0000 + 32'(c);
      settle();
      exp_v = {scyc_v[c], g_exp[c], 1'b0, m1a_v[c]};
      checks++;
      if ({s_cyc, grant, m0_ack, m1_ack} !== exp_v) begin
        errors++;
        $display("FAIL abort_c%0d: {s_cyc,grant,m0_ack,m1_ack}=%b required %b", c, {s_cyc, grant, m0_ack, m1_ack}, exp_v);
      end
      if (c == 5) begin
        checks++;
        if (s_adr !== 32'h6000_0000) begin
          errors++;
          $display("FAIL abort_m1_addr: s_adr=%h required 60000000", s_adr);
        end
        $display("[%0t] abort: m0 aborted, m1 acked rdat=%h", $time, m1_rdat);
      end
    end
    idle_bus();
  endtask

  initial begin
    arstn  = 1'b0;
    m0_adr = '0; m0_wdat = '0; m0_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0; m0_sel = '0;
    m1_adr = '0; m1_wdat = '0; m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0; m1_sel = '0;
    s_rdat = '0; s_ack = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_block_hold();
    test_timeout();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
